reproductor_melodia: RTL and testbench

REPRODUCTOR_MELODIA -- requirements
Module: reproductor_melodia

---
 rtl/melodia_pkg.sv | 50 +++++
 rtl/reproductor_melodia_divisor_tono.sv | 32 +++
 rtl/reproductor_melodia.sv | 156 +++++++++++++++
 tb/tb_reproductor_melodia.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/melodia_pkg.sv
// Shared types and constant tables for the two-melody buzzer player.
// Tables use 50 MHz half-period counts; each melody entry is {code[3:0], dur[3:0]}.
package melodia_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } melodia_state_t;

    // Code 0 and codes 13..15 are rests; 1..12 run A4..G#5.
    localparam logic [16:0] HALF_PERIOD [0:15] = '{
        17'd0,     17'd56818, 17'd53629, 17'd50619,
        17'd47778, 17'd45097, 17'd42566, 17'd40177,
        17'd37922, 17'd35793, 17'd33784, 17'd31888,
        17'd30098, 17'd0,     17'd0,     17'd0
    };

    localparam logic [7:0] MEL_A [0:15] = '{
        8'h13, 8'h10, 8'h52, 8'h01, 8'h64, 8'h82, 8'hA1, 8'hC3,
        8'hD2, 8'h31, 8'h21, 8'h42, 8'h71, 8'h92, 8'hB1, 8'h02
    };

    localparam logic [7:0] MEL_B [0:15] = '{
        8'h42, 8'h41, 8'h63, 8'h02, 8'h81, 8'h95, 8'hB2, 8'hE1,
        8'hC1, 8'hA2, 8'h50, 8'h31, 8'h22, 8'h14, 8'hF1, 8'h73
    };

    function automatic logic [16:0] half_period_of(input logic [3:0] code, input int shift);
        logic [16:0] hp;
        hp = HALF_PERIOD[code] >> shift;
        if (hp == 17'd0) begin
            hp = 17'd1;
        end else begin
            hp = hp;
        end
        return hp;
    endfunction

    function automatic logic is_tone(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd12);
    endfunction

    // A stored duration of 0 means the longest note, 16 ticks.
    function automatic logic [4:0] dur_ticks(input logic [3:0] dur);
        return (dur == 4'd0) ? 5'd16 : {1'b0, dur};
    endfunction

endpackage

// File: rtl/reproductor_melodia_divisor_tono.sv
// Square-wave generator: toggles buzzer every hp cycles while enabled,
// and snaps back to a silent, zeroed state whenever enable drops.
module divisor_tono (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [16:0] hp,
    output logic        buzzer
);

    logic [16:0] cnt_r;
    logic        buzzer_r;

    // Tone counter and output toggle flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r    <= 17'd0;
            buzzer_r <= 1'b0;
        end else if (!enable) begin
            cnt_r    <= 17'd0;
            buzzer_r <= 1'b0;
        end else if (cnt_r >= hp - 17'd1) begin
            cnt_r    <= 17'd0;
            buzzer_r <= ~buzzer_r;
        end else begin
            cnt_r    <= cnt_r + 17'd1;
        end
    end

    assign buzzer = buzzer_r;

endmodule

// File: rtl/reproductor_melodia.sv
// Melody sequencer: steps through a 16-note ROM selected by estado,
// playing each note for dur ticks followed by a one-tick silent gap.
module reproductor_melodia
    import melodia_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int HP_SHIFT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] estado,
    output logic       buzzer,
    output logic       playing,
    output logic [3:0] nota_idx
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    melodia_state_t state_r, state_next_s;
    logic [1:0]     estado_q_r, estado_qq_r;
    logic [TW-1:0]  tick_cnt_r;
    logic [4:0]     dur_cnt_r;
    logic [3:0]     code_r, dur_r, nota_idx_r, nota_next_s;
    logic           playing_r, playing_next_s;
    logic           chg_s, sel_valid_s, tick_s, last_tick_s, entry_s, tone_en_s;
    logic [7:0]     rom_s;
    logic [16:0]    hp_s;

    // Input capture plus one extra stage used to spot changes of the selection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q_r  <= 2'b00;
            estado_qq_r <= 2'b00;
        end else begin
            estado_q_r  <= estado;
            estado_qq_r <= estado_q_r;
        end
    end

    assign chg_s       = (estado_q_r != estado_qq_r);
    assign sel_valid_s = (estado_q_r == 2'b01) || (estado_q_r == 2'b10);
    assign tick_s      = (tick_cnt_r == TICK_LAST);
    assign last_tick_s = tick_s && (dur_cnt_r == dur_ticks(dur_r) - 5'd1);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a selection change outranks tick and duration events.
    always_comb begin
        state_next_s = state_r;
        if ((state_r != IDLE) && chg_s) begin
            state_next_s = sel_valid_s ? LOAD : IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = sel_valid_s ? LOAD : IDLE;
                LOAD:    state_next_s = PLAY;
                PLAY:    state_next_s = last_tick_s ? GAP : PLAY;
                GAP:     state_next_s = tick_s ? LOAD : GAP;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Output logic: next values for the registered status outputs.
    always_comb begin
        playing_next_s = (state_next_s != IDLE);
        nota_next_s    = nota_idx_r;
        case (state_next_s)
            IDLE: nota_next_s = 4'd0;
            LOAD: begin
                if ((state_r == GAP) && !chg_s) begin
                    nota_next_s = nota_idx_r + 4'd1;
                end else begin
                    nota_next_s = 4'd0;
                end
            end
            default: nota_next_s = nota_idx_r;
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            playing_r  <= 1'b0;
            nota_idx_r <= 4'd0;
        end else begin
            playing_r  <= playing_next_s;
            nota_idx_r <= nota_next_s;
        end
    end

    // ROM read for the note about to play.
    always_comb begin
        if (estado_q_r == 2'b10) begin
            rom_s = MEL_B[nota_idx_r];
        end else begin
            rom_s = MEL_A[nota_idx_r];
        end
    end

    assign entry_s = (state_next_s != state_r) &&
                     ((state_next_s == PLAY) || (state_next_s == GAP));

    // Tick divider, duration counter and latched note fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= '0;
            dur_cnt_r  <= 5'd0;
            code_r     <= 4'd0;
            dur_r      <= 4'd0;
        end else begin
            if (entry_s || tick_s) begin
                tick_cnt_r <= '0;
            end else begin
                tick_cnt_r <= tick_cnt_r + 1'b1;
            end
            if ((state_next_s == PLAY) && (state_r != PLAY)) begin
                dur_cnt_r <= 5'd0;
            end else if ((state_r == PLAY) && tick_s) begin
                dur_cnt_r <= dur_cnt_r + 5'd1;
            end else begin
                dur_cnt_r <= dur_cnt_r;
            end
            if (state_r == LOAD) begin
                code_r <= rom_s[7:4];
                dur_r  <= rom_s[3:0];
            end else begin
                code_r <= code_r;
                dur_r  <= dur_r;
            end
        end
    end

    // Dropping enable on the last PLAY cycle leaves the buzzer low when the gap or abort begins.
    assign tone_en_s = (state_r == PLAY) && (state_next_s == PLAY) && is_tone(code_r);
    assign hp_s      = half_period_of(code_r, HP_SHIFT);

    divisor_tono u_divisor_tono (
        .clk    (clk),
        .reset  (reset),
        .enable (tone_en_s),
        .hp     (hp_s),
        .buzzer (buzzer)
    );

    assign playing  = playing_r;
    assign nota_idx = nota_idx_r;

endmodule

// File: tb/tb_reproductor_melodia.sv
// Bench for reproductor_melodia: a timeline model of the melody player
// checked every cycle, plus directed checks at hand-computed cycle offsets.
module tb_reproductor_melodia;
    import melodia_pkg::*;

    localparam int TD = 4;
    localparam int SH = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] estado = 2'b00;
    logic       buzzer;
    logic       playing;
    logic [3:0] nota_idx;

    int errors = 0;
    int checks = 0;

    reproductor_melodia #(.TICK_DIV(TD), .HP_SHIFT(SH)) dut (
        .clk      (clk),
        .reset    (reset),
        .estado   (estado),
        .buzzer   (buzzer),
        .playing  (playing),
        .nota_idx (nota_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", nm, got, expv, $time);
        end
    endtask

    function automatic int dticks(input logic [3:0] d);
        return (d == 4'd0) ? 16 : int'(d);
    endfunction

    function automatic int hp_of(input logic [3:0] c);
        int h;
        h = int'(HALF_PERIOD[c]) >> SH;
        if (h < 1) h = 1;
        return h;
    endfunction

    function automatic logic [7:0] entry_of(input logic [1:0] mel, input int i);
        return (mel == 2'b10) ? MEL_B[i] : MEL_A[i];
    endfunction

    // Timeline model: each note is 1 load cycle, TD*dur play cycles, TD gap cycles.
    function automatic void expect_at(input bit act, input logic [1:0] mel, input int t,
                                      output int eb, output int ep, output int en);
        int total, tt, len, idx, off, d, k;
        bit found;
        logic [7:0] e;
        eb = 0; ep = 0; en = 0;
        if (act) begin
            total = 0;
            for (int i = 0; i < 16; i++) begin
                e = entry_of(mel, i);
                total += 1 + TD * dticks(e[3:0]) + TD;
            end
            tt = t % total;
            found = 0; idx = 0; off = 0;
            for (int i = 0; i < 16; i++) begin
                e = entry_of(mel, i);
                len = 1 + TD * dticks(e[3:0]) + TD;
                if (!found) begin
                    if (tt < len) begin
                        found = 1; idx = i; off = tt;
                    end else begin
                        tt -= len;
                    end
                end
            end
            e = entry_of(mel, idx);
            d = dticks(e[3:0]);
            ep = 1;
            en = idx;
            if (off >= 1 && off <= TD * d && e[7:4] >= 4'd1 && e[7:4] <= 4'd12) begin
                k = off - 1;
                eb = ((k / hp_of(e[7:4])) % 2);
            end
        end
    endfunction

    // Model: a change of the one-cycle-delayed selection restarts or stops playback.
    logic [1:0] m_q = 2'b00, m_qq = 2'b00, m_mel = 2'b00;
    bit         m_act = 1'b0;
    int         m_t = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q = 2'b00; m_qq = 2'b00; m_act = 1'b0; m_t = 0; m_mel = 2'b00;
        end else begin
            if (m_q != m_qq) begin
                m_act = (m_q == 2'b01) || (m_q == 2'b10);
                m_mel = m_q;
                m_t = 0;
            end else if (m_act) begin
                m_t++;
            end
            m_qq = m_q;
            m_q = estado;
        end
    end

    int eb_v, ep_v, en_v;
    always @(negedge clk) begin
        expect_at(m_act, m_mel, m_t, eb_v, ep_v, en_v);
        chk("model_buzzer", int'(buzzer), eb_v);
        chk("model_playing", int'(playing), ep_v);
        chk("model_nota_idx", int'(nota_idx), en_v);
    end

    int td = 0;
    task automatic goto_t(input int target);
        repeat (target - td) @(negedge clk);
        td = target;
    endtask

    task automatic wait_buzz(input string nm);
        int n;
        n = 0;
        while (buzzer !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(buzzer === 1'b1), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_buzzer", int'(buzzer), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_nota", int'(nota_idx), 0);
        reset = 1'b1;
        @(negedge clk);

        // Start melody A; t counts negedges from the first LOAD cycle.
        estado = 2'b01;
        @(negedge clk);
        chk("start_playing_lat1", int'(playing), 0);
        @(negedge clk);
        td = 0;
        chk("start_playing_lat2", int'(playing), 1);
        chk("start_nota0", int'(nota_idx), 0);
        goto_t(12);
        chk("n0_play_last_playing", int'(playing), 1);
        chk("n0_buzzer_silent", int'(buzzer), 0);
        goto_t(13);
        chk("n0_gap_buzzer", int'(buzzer), 0);
        chk("n0_gap_nota", int'(nota_idx), 0);
        goto_t(16);
        chk("n0_gap_end_nota", int'(nota_idx), 0);
        goto_t(17);
        chk("n1_nota", int'(nota_idx), 1);
        goto_t(72);
        chk("n1_buzz_before", int'(buzzer), 0);
        goto_t(73);
        chk("n1_buzz_toggle", int'(buzzer), 1);
        goto_t(255);
        chk("wrap_nota15", int'(nota_idx), 15);
        goto_t(256);
        chk("wrap_nota0", int'(nota_idx), 0);
        chk("wrap_playing", int'(playing), 1);
        goto_t(300);

        // Switch melody mid-note.
        estado = 2'b10;
        repeat (2) @(negedge clk);
        chk("switch_nota0", int'(nota_idx), 0);
        chk("switch_playing", int'(playing), 1);
        chk("switch_buzzer", int'(buzzer), 0);

        // Silence select while the buzzer is high.
        estado = 2'b01;
        wait_buzz("wait_buzz_silence");
        estado = 2'b11;
        repeat (2) @(negedge clk);
        chk("silence_buzzer", int'(buzzer), 0);
        chk("silence_playing", int'(playing), 0);

        // Asynchronous reset mid-note.
        estado = 2'b01;
        wait_buzz("wait_buzz_reset");
        #2 reset = 1'b0;
        #1;
        chk("async_rst_buzzer", int'(buzzer), 0);
        chk("async_rst_playing", int'(playing), 0);
        chk("async_rst_nota", int'(nota_idx), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("restart_lat1", int'(playing), 0);
        @(negedge clk);
        chk("restart_playing", int'(playing), 1);
        chk("restart_nota0", int'(nota_idx), 0);

        // Random selection sequences with occasional reset pulses.
        repeat (40) begin
            estado = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 300)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                #3 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
